// File: rtl/tree_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tree_phase_scheduler
// Brief    : Load/query sequencer for the k-d tree internal-node datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tree_phase_scheduler #(
    parameter int PATCH_WIDTH   = 55,
    parameter int ADDRESS_WIDTH = 8,
    parameter int NUM_NODES     = 63,
    parameter int TREE_LATENCY  = 6,
    parameter int TAG_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     wrst_n,
    input  logic                     start,
    input  logic                     load_enq,
    output logic                     load_full_n,
    output logic                     tree_fsm_enable,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic [PATCH_WIDTH-1:0]   q_patch,
    input  logic                     q_last,
    output logic                     tree_patch_en,
    output logic [PATCH_WIDTH-1:0]   tree_patch_in,
    input  logic                     tree_leaf_en,
    input  logic [ADDRESS_WIDTH-1:0] tree_leaf_index,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [TAG_WIDTH-1:0]     r_tag,
    output logic [ADDRESS_WIDTH-1:0] r_leaf,
    output logic                     r_last,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] nodes_loaded,
    output logic [1:0]               err
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENTRY_W = TAG_WIDTH + ADDRESS_WIDTH + 1;

    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_NODE = ADDRESS_WIDTH'(NUM_NODES - 1);
    localparam logic [c_CNT_W-1:0]       c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]       c_PTR_MAX   = c_PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_QUERY = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [c_CNT_W-1:0]   r_outstanding;
    logic [TAG_WIDTH-1:0] r_tag_ctr;

    logic                 r_exp_valid [0:TREE_LATENCY];
    logic [TAG_WIDTH-1:0] r_exp_tag   [0:TREE_LATENCY];
    logic                 r_exp_last  [0:TREE_LATENCY];

    logic [c_ENTRY_W-1:0] r_fifo_mem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_fifo_cnt;

    logic       w_accept;
    logic       w_last_write;
    logic       w_start_ok;
    logic       w_phase_q;
    logic       w_exp_valid;
    logic       w_push;
    logic       w_pop;
    logic       w_miss;
    logic       w_lat_err;
    logic [1:0] w_dec;

    // ------------------------------------------------------------------
    // Status and handshake decode (all from registered state)
    // ------------------------------------------------------------------
    assign load_full_n     = (r_state == S_LOAD);
    assign tree_fsm_enable = (r_state == S_LOAD);
    assign q_ready         = (r_state == S_QUERY) && (r_outstanding < c_DEPTH);
    assign busy            = (r_state == S_LOAD) || (r_state == S_QUERY) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);

    assign w_accept     = q_valid & q_ready;
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_write = (r_state == S_LOAD) && load_enq && (nodes_loaded == c_LAST_NODE);

    // Tree strobes only mean anything while queries can be in flight; this
    // also mutes strobes still emerging from the tree after a reset.
    assign w_phase_q   = (r_state == S_QUERY) || (r_state == S_DRAIN);
    assign w_exp_valid = r_exp_valid[TREE_LATENCY];
    assign w_push      = w_phase_q & w_exp_valid & tree_leaf_en;
    assign w_miss      = w_phase_q & w_exp_valid & ~tree_leaf_en;
    assign w_lat_err   = w_phase_q & (tree_leaf_en != w_exp_valid);
    assign w_pop       = r_valid & r_ready;
    assign w_dec       = {1'b0, w_pop} + {1'b0, w_miss};

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                w_state_next = S_LOAD;
            S_LOAD:  if (w_last_write)         w_state_next = S_QUERY;
            S_QUERY: if (w_accept && q_last)   w_state_next = S_DRAIN;
            S_DRAIN: if (r_outstanding == '0)  w_state_next = S_DONE;
            S_DONE:  if (start)                w_state_next = S_LOAD;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load counter and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            nodes_loaded <= '0;
            err          <= 2'b00;
        end else begin
            if (w_start_ok) begin
                nodes_loaded <= '0;
            end else if ((r_state == S_LOAD) && load_enq) begin
                nodes_loaded <= nodes_loaded + ADDRESS_WIDTH'(1);
            end
            if (w_lat_err) begin
                err[0] <= 1'b1;
            end
            if (load_enq && (r_state != S_LOAD)) begin
                err[1] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Query tag and outstanding count; the count covers in-flight queries
    // plus buffered results, so it bounds FIFO occupancy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            r_tag_ctr     <= '0;
            r_outstanding <= '0;
        end else if (w_last_write) begin
            r_tag_ctr     <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_accept) begin
                r_tag_ctr <= r_tag_ctr + TAG_WIDTH'(1);
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_dec);
        end
    end

    // ------------------------------------------------------------------
    // Patch launch register and expected-result shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            tree_patch_en <= 1'b0;
            tree_patch_in <= '0;
            for (int i = 0; i <= TREE_LATENCY; i++) begin
                r_exp_valid[i] <= 1'b0;
                r_exp_tag[i]   <= '0;
                r_exp_last[i]  <= 1'b0;
            end
        end else begin
            tree_patch_en <= w_accept;
            if (w_accept) begin
                tree_patch_in <= q_patch;
            end
            r_exp_valid[0] <= w_accept;
            r_exp_tag[0]   <= r_tag_ctr;
            r_exp_last[0]  <= w_accept & q_last;
            for (int i = 1; i <= TREE_LATENCY; i++) begin
                r_exp_valid[i] <= r_exp_valid[i-1];
                r_exp_tag[i]   <= r_exp_tag[i-1];
                r_exp_last[i]  <= r_exp_last[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through result buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {r_exp_tag[TREE_LATENCY], tree_leaf_index,
                                         r_exp_last[TREE_LATENCY]};
                r_wr_ptr <= (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    assign r_valid                 = (r_fifo_cnt != '0);
    assign {r_tag, r_leaf, r_last} = r_fifo_mem[r_rd_ptr];

endmodule
`default_nettype wire
